// File: rtl/cmplx_mul_seq_pkg.sv
// cmul_pkg: shared definitions for the sequential complex multiplier.
//   W  : operand width (fixed at 16 by vedic16)
//   PW : width of one partial product (2W)
//   RW : width of the result accumulators (2W+1)
//   state_t : FSM states. P4 is only reachable when CMUL_PROD_REG_EN is defined.
package cmul_pkg;

  localparam int W  = 16;
  localparam int PW = 2 * W;
  localparam int RW = 2 * W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    P4   = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/vedic16.sv
// vedic16: combinational 16x16 unsigned multiplier.
// The product is built from four 8x8 partial products
// (vertical and crosswise decomposition).
// Ports:
//   a, b : 16-bit unsigned operands
//   p    : 32-bit unsigned product
module vedic16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [15:0] ll;
  logic [15:0] lh;
  logic [15:0] hl;
  logic [15:0] hh;

  assign ll = {8'b0, a[7:0]}  * {8'b0, b[7:0]};
  assign lh = {8'b0, a[7:0]}  * {8'b0, b[15:8]};
  assign hl = {8'b0, a[15:8]} * {8'b0, b[7:0]};
  assign hh = {8'b0, a[15:8]} * {8'b0, b[15:8]};

  // The full product always fits in 32 bits, so the sum cannot overflow.
  assign p = {hh, ll} + {8'b0, lh, 8'b0} + {8'b0, hl, 8'b0};

endmodule

// File: rtl/cmplx_mul_seq.sv
// cmplx_mul_seq: sequential complex multiplier.
// It computes (ar + j*ai) * (br + j*bi) using one vedic16 instance.
// The four partial products are issued on four successive cycles.
//   re = ar*br - ai*bi  (2W+1 bit two's complement)
//   im = ar*bi + ai*br  (2W+1 bit unsigned)
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   ar, ai, br, bi      : unsigned operand components
//   out_valid/out_ready : result handshake
//   re, im              : result, held stable while out_valid && !out_ready
// Configuration macro CMUL_PROD_REG_EN:
//   Registers the multiplier output and adds a drain state P4.
//   Each product is applied one cycle after its operands are driven.
//   Results are identical; latency and period grow by one cycle.
module cmplx_mul_seq
  import cmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  ar,
  input  logic [W-1:0]  ai,
  input  logic [W-1:0]  br,
  input  logic [W-1:0]  bi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] re,
  output logic [RW-1:0] im
);

  state_t        state;
  logic [W-1:0]  ar_q, ai_q, br_q, bi_q;
  logic [RW-1:0] re_acc, im_acc;
  logic [W-1:0]  mul_a, mul_b;
  logic [PW-1:0] prod;
  logic [PW-1:0] acc_in;
  logic [RW-1:0] acc_ext;
  logic          accept;
  logic          term_en;
  logic [1:0]    term;

  // DONE with out_ready accepts new operands directly, avoiding an IDLE cycle.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Pick the partial-product operand pair for the current state.
  always_comb begin
    mul_a = ar_q;
    mul_b = br_q;
    case (state)
      P1:      begin mul_a = ai_q; mul_b = bi_q; end
      P2:      begin mul_a = ar_q; mul_b = bi_q; end
      P3:      begin mul_a = ai_q; mul_b = br_q; end
      default: begin mul_a = ar_q; mul_b = br_q; end
    endcase
  end

  vedic16 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

`ifdef CMUL_PROD_REG_EN
  logic [PW-1:0] prod_q;

  always_ff @(posedge clk) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod;
  end

  assign acc_in = prod_q;
`else
  assign acc_in = prod;
`endif

  assign acc_ext = {1'b0, acc_in};

  // Select which accumulator term is applied this cycle.
  // With the product register, each term trails its operand state by one.
  always_comb begin
    term_en = 1'b1;
    term    = 2'd0;
    case (state)
`ifdef CMUL_PROD_REG_EN
      P1:      term = 2'd0;
      P2:      term = 2'd1;
      P3:      term = 2'd2;
      P4:      term = 2'd3;
`else
      P0:      term = 2'd0;
      P1:      term = 2'd1;
      P2:      term = 2'd2;
      P3:      term = 2'd3;
`endif
      default: term_en = 1'b0;
    endcase
  end

  // Control FSM, operand latches and the accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      re_acc    <= '0;
      im_acc    <= '0;
      ar_q      <= '0;
      ai_q      <= '0;
      br_q      <= '0;
      bi_q      <= '0;
    end else begin
      if (term_en) begin
        case (term)
          2'd0:    re_acc <= acc_ext;
          2'd1:    re_acc <= re_acc - acc_ext;
          2'd2:    im_acc <= acc_ext;
          default: im_acc <= im_acc + acc_ext;
        endcase
      end

      if (accept) begin
        ar_q <= ar;
        ai_q <= ai;
        br_q <= br;
        bi_q <= bi;
      end

      case (state)
        IDLE: if (accept) state <= P0;
        P0:   state <= P1;
        P1:   state <= P2;
        P2:   state <= P3;
`ifdef CMUL_PROD_REG_EN
        P3:   state <= P4;
        P4: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
`else
        P3: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? P0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign re = re_acc;
  assign im = im_acc;

endmodule

// File: tb/tb_cmplx_mul_seq.sv
// tb_cmplx_mul_seq: directed self-checking bench for cmplx_mul_seq.
// It uses hand-computed expected results for reset, latency, full-scale
// operands, negative real part, back-pressure, mid-transaction reset and
// back-to-back throughput.
// Honours CMUL_PROD_REG_EN for the expected latency and period.
module tb_cmplx_mul_seq;

`ifdef CMUL_PROD_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int PERIOD = LAT + 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ar, ai, br, bi;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] re, im;

  int compared   = 0;
  int mismatched = 0;

  cmplx_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .re        (re),
    .im        (im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and wait for the accept edge.
  // Returns at the falling edge after acceptance, with in_valid dropped.
  task automatic applyStimulus(input logic [15:0] a_r, a_i, b_r, b_i);
    int guard;
    ar = a_r; ai = a_i; br = b_r; bi = b_i;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Walk the latency after an accept edge, checking out_valid each cycle
  // and the result once it appears.
  task automatic waitResult(input string tag, input logic [32:0] exp_re, input logic [32:0] exp_im);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); @(negedge clk);
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'(c == LAT));
    end
    checkOutput({tag, "_re"}, 64'(re), 64'(exp_re));
    checkOutput({tag, "_im"}, 64'(im), 64'(exp_im));
  endtask

  initial begin
    int pulses;
    int t_prev;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ar = '0; ai = '0; br = '0; bi = '0;

    // Reset held 3 cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("rst_re",        64'(re),        64'd0);
    checkOutput("rst_im",        64'(im),        64'd0);

    // (3+4j)(5+6j) = -9 + 38j
    applyStimulus(16'd3, 16'd4, 16'd5, 16'd6);
    waitResult("small", 33'h1FFFFFFF7, 33'd38);

    // All full scale: re 0, im 2*(0xFFFF^2); accepted via DONE bypass.
    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    waitResult("full", 33'd0, 33'h1FFFC0002);

    // Most negative real part.
    applyStimulus(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);
    waitResult("neg", 33'h10001FFFF, 33'd0);

    // Back-pressure: previous result pending, new operands waiting.
    out_ready = 1'b0;
    ar = 16'd3; ai = 16'd4; br = 16'd5; bi = 16'd6;
    in_valid = 1'b1;
    #1;
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checkOutput("bp_valid_held", 64'(out_valid), 64'd1);
      checkOutput("bp_re_held",    64'(re),        64'h10001FFFF);
      checkOutput("bp_im_held",    64'(im),        64'd0);
      checkOutput("bp_in_ready",   64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
    waitResult("bp", 33'h1FFFFFFF7, 33'd38);

    // Reset pulsed while the multiplier is in P2.
    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("midrst_re",        64'(re),        64'd0);
    checkOutput("midrst_im",        64'(im),        64'd0);
    applyStimulus(16'd3, 16'd4, 16'd5, 16'd6);
    waitResult("post_rst", 33'h1FFFFFFF7, 33'd38);

    // Back-to-back with in_valid and out_ready held high.
    ar = 16'd3; ai = 16'd4; br = 16'd5; bi = 16'd6;
    in_valid = 1'b1;
    pulses = 0;
    t_prev = 0;
    for (int n = 1; n <= 40 && pulses < 3; n++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          checkOutput("b2b_first_lat", 64'(n), 64'(LAT + 1));
          checkOutput("b2b_p1_re", 64'(re), 64'h1FFFFFFF7);
          checkOutput("b2b_p1_im", 64'(im), 64'd38);
          ar = 16'h0000; ai = 16'hFFFF; br = 16'h0000; bi = 16'hFFFF;
        end else begin
          checkOutput("b2b_gap", 64'(n - t_prev), 64'(PERIOD));
          checkOutput("b2b_re", 64'(re), 64'h10001FFFF);
          checkOutput("b2b_im", 64'(im), 64'd0);
        end
        t_prev = n;
      end
    end
    checkOutput("b2b_pulse_count", 64'(pulses), 64'd3);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cmplx_mul_seq.md
# cmplx_mul_seq

Sequential complex multiplier built around one instance of the 16x16 unsigned `vedic16` multiplier. It accepts a complex operand pair (ar + j·ai) × (br + j·bi) over a valid/ready handshake. It drives the four partial-product operand pairs into `vedic16` on successive cycles and consumes each 32-bit product into real and imaginary accumulators. It sits directly upstream and downstream of `vedic16`, trading throughput for one multiplier's area.

## Interface
- W, 16, operand width; only 16 is legal (bound by `vedic16`)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- ar, ai, br, bi  in  W each  unsigned operand components
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- re  out  2W+1  signed real part, two's complement: ar·br − ai·bi
- im  out  2W+1  unsigned imaginary part: ar·bi + ai·br

## Operation
- States: IDLE, P0, P1, P2, P3, DONE.
- Accept condition: `in_valid && in_ready`.
  - On accept, ar/ai/br/bi are latched and the state moves to P0.
  - Inputs are ignored at all other times.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- Per-state multiplier operands and accumulator update, at the clock edge ending the state:
  - P0: ar×br; re_acc ← zero-extended product
  - P1: ai×bi; re_acc ← re_acc − product
  - P2: ar×bi; im_acc ← product
  - P3: ai×br; im_acc ← im_acc + product
- After P3 the state is DONE and `out_valid` is 1.
  - `re`/`im` are driven from the accumulators and stay stable while out_valid && !out_ready.
- DONE with out_ready:
  - if in_valid is also high, accept the new operands and go to P0 (same edge);
  - otherwise go to IDLE.
- Arithmetic is 2W+1 bits wide with no overflow:
  - re range is −(2^32−2^17+1) .. +(2^32−2^17+1);
  - im max is 0x1FFFC0002.
- Reset in any state:
  - next state IDLE; re_acc = im_acc = 0; out_valid = 0; in_ready = 1;
  - any in-flight transaction is discarded with no partial output.

## Timing
- Reset values: out_valid 0, in_ready 1, re 0, im 0.
- Latency: out_valid rises 4 cycles after the accept edge (accept at edge k, out_valid visible after edge k+4).
- Throughput:
  - one result per 5 cycles when in_valid is held and out_ready=1;
  - the DONE→P0 bypass avoids an IDLE cycle.
- `vedic16` is combinational. Its product is sampled in the same cycle its operands are driven.
- `in_ready` is combinational from state and out_ready. No other output depends combinationally on inputs.

## Configuration
- `CMUL_PROD_REG_EN` defined:
  - inserts a register between the `vedic16` output and the accumulators;
  - adds a one-cycle drain state P4 after P3;
  - each product is applied one cycle after its operands are driven;
  - latency is 5 cycles, throughput is one result per 6 cycles;
  - the product register resets to 0.
- `CMUL_PROD_REG_EN` undefined: behaviour is exactly as described above.
- Results are bit-identical in both configurations.

## Structure
- Package `cmul_pkg`:
  - state enum (IDLE, P0–P3, P4, DONE);
  - localparams W=16, PW=2W, RW=2W+1.
- Sub-modules:
  - one existing `vedic16` instance, driven by a 4:1 operand mux indexed by state;
  - no new sub-module; FSM, mux and accumulators live in `cmplx_mul_seq`.

## Test plan
- Reset held 3 cycles, then released → out_valid 0, in_ready 1, re 0, im 0.
- ar=3, ai=4, br=5, bi=6, out_ready=1 → after 4 cycles out_valid=1, re=−9 (0x1FFFFFFF7), im=38.
- All operands 0xFFFF → re=0, im=0x1FFFC0002.
- ar=0, ai=0xFFFF, br=0, bi=0xFFFF → re=0x10001FFFF (−0xFFFE0001), im=0.
- Result pending, out_ready low 3 cycles, in_valid high with new operands:
  - re/im held, in_ready 0;
  - when out_ready rises, new operands accepted that edge and the next result is correct.
- rst pulsed during P2:
  - next cycle state IDLE, out_valid 0, in_ready 1;
  - following transaction 3,4,5,6 gives re=−9, im=38.
- Back-to-back with in_valid and out_ready held high → out_valid pulses every 5 cycles (6 with `CMUL_PROD_REG_EN`).
